// File: rtl/i2s_tdm_reader_phy_if.sv
// Ping-pong write-FIFO bus: the capture PHY is master, the FIFO pair is slave.
// Strobe/data are valid only while a FIFO is activated; ready is per FIFO.
interface i2s_tdm_reader_phy_if;
    logic [23:0] i_min_read_size;
    logic [23:0] i_wfifo_size;
    logic [1:0]  i_wfifo_ready;
    logic [1:0]  o_wfifo_activate;
    logic        o_wfifo_strobe;
    logic [31:0] o_wfifo_data;

    modport master (
        input  i_min_read_size, i_wfifo_size, i_wfifo_ready,
        output o_wfifo_activate, o_wfifo_strobe, o_wfifo_data
    );
    modport slave (
        output i_min_read_size, i_wfifo_size, i_wfifo_ready,
        input  o_wfifo_activate, o_wfifo_strobe, o_wfifo_data
    );
endinterface

// File: rtl/i2s_tdm_reader_phy.sv
// I2S/TDM capture PHY: one 32-bit word per slot, written the cycle after the sample's last bit.
// No FIFO owned when a word is due: the word is dropped and counted as overflow.
module i2s_tdm_reader_phy #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int SLOT_WIDTH   = 32,
    parameter int CHANNELS     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_enable,
    input  logic                  i_sign_extend,
    i2s_tdm_reader_phy_if.master  wfifo,
    output logic                  o_sync_error,
    output logic [15:0]           o_overflow_count,
    input  logic                  i_i2s_lr,
    input  logic                  i_i2s_data
);
    localparam logic [5:0] LP_BIT_LAST  = 6'(SLOT_WIDTH - 1);
    localparam logic [5:0] LP_SMP_LAST  = 6'(SAMPLE_WIDTH - 1);
    localparam logic [3:0] LP_SLOT_LAST = 4'(CHANNELS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_CAPTURE, ST_DONE} state_t;
    state_t r_state, w_state_nxt;

    logic [5:0]              r_bit;
    logic [3:0]              r_slot;
    logic                    r_prev_lr;
    logic [SAMPLE_WIDTH-2:0] r_shift;
    logic                    r_pend;
    logic [31:0]             r_data;
    logic [1:0]              r_act;
    logic [23:0]             r_wcnt;
    logic                    r_sync_error;
    logic [15:0]             r_ovf;

    logic                    w_fs, w_last_bit, w_last_pos;
    logic                    w_cnt_clr, w_cnt_adv, w_smp_done, w_err;
    logic [SAMPLE_WIDTH-1:0] w_sample;
    logic [31:0]             w_word;
    logic                    w_act_any, w_strobe, w_other_rdy;
    logic [23:0]             w_wcnt_inc;

    assign w_fs       = r_prev_lr & ~i_i2s_lr;
    assign w_last_bit = (r_bit == LP_BIT_LAST);
    assign w_last_pos = w_last_bit && (r_slot == LP_SLOT_LAST);
    assign w_sample   = {r_shift, i_i2s_data};
    assign w_act_any  = |r_act;
    assign w_strobe   = r_pend & w_act_any;
    assign w_other_rdy = r_act[0] ? wfifo.i_wfifo_ready[1] : wfifo.i_wfifo_ready[0];
    assign w_wcnt_inc = r_wcnt + 24'd1;

    assign wfifo.o_wfifo_activate = r_act;
    assign wfifo.o_wfifo_strobe   = w_strobe;
    assign wfifo.o_wfifo_data     = r_data;
    assign o_sync_error           = r_sync_error;
    assign o_overflow_count       = r_ovf;

    always_comb begin
        w_word = '0;
        if (i_sign_extend) begin
            w_word = {{(32-SAMPLE_WIDTH){w_sample[SAMPLE_WIDTH-1]}}, w_sample};
        end else begin
            w_word[SAMPLE_WIDTH-1:0] = w_sample;
            w_word[31:24]            = {4'd0, r_slot};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_cnt_adv   = 1'b0;
        w_smp_done  = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            ST_IDLE: if (i_enable) w_state_nxt = ST_SYNC;
            ST_SYNC, ST_DONE: begin
                if (w_fs) begin
                    w_state_nxt = ST_CAPTURE;
                    w_cnt_clr   = 1'b1;
                end
            end
            ST_CAPTURE: begin
                // A frame start before the last bit of the last slot is a short frame.
                if (w_fs && !w_last_pos) begin
                    w_err     = 1'b1;
                    w_cnt_clr = 1'b1;
                end else begin
                    w_cnt_adv  = 1'b1;
                    w_smp_done = (r_bit == LP_SMP_LAST);
                    if (w_last_pos) begin
                        w_cnt_clr = 1'b1;
                        if (!w_fs) w_state_nxt = ST_DONE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (!i_enable) begin
            w_state_nxt = ST_IDLE;
            w_cnt_clr   = 1'b1;
            w_smp_done  = 1'b0;
            w_err       = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit        <= '0;
            r_slot       <= '0;
            r_prev_lr    <= 1'b0;
            r_shift      <= '0;
            r_pend       <= 1'b0;
            r_data       <= '0;
            r_sync_error <= 1'b0;
        end else begin
            r_prev_lr    <= i_i2s_lr;
            r_sync_error <= w_err;
            r_pend       <= w_smp_done;
            if (r_state == ST_CAPTURE) r_shift <= {r_shift[SAMPLE_WIDTH-3:0], i_i2s_data};
            if (w_smp_done) r_data <= w_word;
            if (w_cnt_clr) begin
                r_bit  <= '0;
                r_slot <= '0;
            end else if (w_cnt_adv) begin
                if (w_last_bit) begin
                    r_bit  <= '0;
                    r_slot <= r_slot + 4'd1;
                end else begin
                    r_bit <= r_bit + 6'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_act  <= '0;
            r_wcnt <= '0;
            r_ovf  <= '0;
        end else begin
            if (r_pend && !w_act_any && r_ovf != 16'hFFFF) r_ovf <= r_ovf + 16'd1;
            if (!i_enable) begin
                r_act  <= '0;
                r_wcnt <= '0;
            end else if (!w_act_any) begin
                if (wfifo.i_wfifo_size != '0 && wfifo.i_wfifo_ready != '0) begin
                    r_act  <= wfifo.i_wfifo_ready[0] ? 2'b01 : 2'b10;
                    r_wcnt <= '0;
                end
            end else if (w_strobe) begin
                r_wcnt <= w_wcnt_inc;
                if (w_wcnt_inc == wfifo.i_wfifo_size) r_act <= '0;
            end else if (r_wcnt >= wfifo.i_min_read_size && r_wcnt != '0 && w_other_rdy) begin
                // Early hand-over: enough words written and the other FIFO can take over.
                r_act <= '0;
            end
        end
    end
endmodule

// File: tb/tb_i2s_tdm_reader_phy.sv
// Bench for the I2S/TDM capture PHY: a 2-channel and a 4-channel instance driven frame by frame,
// words checked against a per-sample FIFO ownership model.
module tb_i2s_tdm_reader_phy;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]  en, lr, dat;
    logic        se;
    logic [23:0] cfg_min, cfg_size;
    logic [1:0]  cfg_ready;
    logic        sync_err [2];
    logic [15:0] ovf [2];
    logic [1:0]  act_w [2];
    logic        stb_w [2];
    logic [31:0] dat_w [2];

    i2s_tdm_reader_phy_if bus2 ();
    i2s_tdm_reader_phy_if bus4 ();

    assign bus2.i_min_read_size = cfg_min;
    assign bus2.i_wfifo_size    = cfg_size;
    assign bus2.i_wfifo_ready   = cfg_ready;
    assign bus4.i_min_read_size = cfg_min;
    assign bus4.i_wfifo_size    = cfg_size;
    assign bus4.i_wfifo_ready   = cfg_ready;
    assign act_w[0] = bus2.o_wfifo_activate;
    assign stb_w[0] = bus2.o_wfifo_strobe;
    assign dat_w[0] = bus2.o_wfifo_data;
    assign act_w[1] = bus4.o_wfifo_activate;
    assign stb_w[1] = bus4.o_wfifo_strobe;
    assign dat_w[1] = bus4.o_wfifo_data;

    i2s_tdm_reader_phy #(.SAMPLE_WIDTH(24), .SLOT_WIDTH(32), .CHANNELS(2)) u_dut2 (
        .clk(clk), .rst(rst), .i_enable(en[0]), .i_sign_extend(se), .wfifo(bus2),
        .o_sync_error(sync_err[0]), .o_overflow_count(ovf[0]),
        .i_i2s_lr(lr[0]), .i_i2s_data(dat[0]));

    i2s_tdm_reader_phy #(.SAMPLE_WIDTH(24), .SLOT_WIDTH(32), .CHANNELS(4)) u_dut4 (
        .clk(clk), .rst(rst), .i_enable(en[1]), .i_sign_extend(se), .wfifo(bus4),
        .o_sync_error(sync_err[1]), .o_overflow_count(ovf[1]),
        .i_i2s_lr(lr[1]), .i_i2s_data(dat[1]));

    int          errors = 0;
    int          checks = 0;
    int          sel = 0;
    logic [1:0]  m_act = 2'b00;
    int          m_cnt = 0;
    int          m_ovf [2] = '{0, 0};
    logic [33:0] exp_q [$];
    logic [33:0] got_q [$];
    int          exp_err = 0;
    int          got_err = 0;
    int          hook_n = -1;
    logic [1:0]  hook_val = 2'b00;
    logic [23:0] fv [8];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (stb_w[sel]) begin
            got_q.push_back({act_w[sel], dat_w[sel]});
            if (hook_n == got_q.size()) begin
                cfg_ready = hook_val;
                hook_n = -1;
            end
        end
        if (sync_err[sel]) got_err++;
    endtask

    function automatic logic [31:0] fmt(input int slot, input logic [23:0] v);
        if (se) return {{8{v[23]}}, v};
        return {8'(slot), v};
    endfunction

    // Ownership rules applied until nothing changes: grab a FIFO, or hand over early.
    task automatic m_settle();
        for (int k = 0; k < 4; k++) begin
            if (!en[sel]) begin
                m_act = 2'b00;
                m_cnt = 0;
            end else if (m_act == 2'b00) begin
                if (cfg_size != 0 && cfg_ready != 0) begin
                    m_act = cfg_ready[0] ? 2'b01 : 2'b10;
                    m_cnt = 0;
                end
            end else if (m_cnt >= int'(cfg_min) && m_cnt > 0 &&
                         (m_act[0] ? cfg_ready[1] : cfg_ready[0])) begin
                m_act = 2'b00;
            end
        end
    endtask

    task automatic m_sample(input int slot, input logic [23:0] v);
        m_settle();
        if (m_act != 2'b00) begin
            exp_q.push_back({m_act, fmt(slot, v)});
            m_cnt++;
            if (m_cnt == int'(cfg_size)) m_act = 2'b00;
        end else if (m_ovf[sel] < 65535) begin
            m_ovf[sel]++;
        end
        m_settle();
    endtask

    task automatic set_en(input logic v);
        en[sel] = v;
        repeat (3) tick();
        m_settle();
    endtask

    task automatic preamble();
        dat[sel] = 1'b0;
        lr[sel] = 1'b1;
        tick();
        tick();
        lr[sel] = 1'b0;
        tick();
    endtask

    task automatic rand_vals();
        for (int i = 0; i < 8; i++) fv[i] = 24'($urandom);
    endtask

    // n bit clocks; LR falls on the final cycle unless this is the last frame of a burst.
    task automatic send_frame(input int n, input int nch, input bit last);
        int s, b;
        for (int c = 0; c < n; c++) begin
            s = c / 32;
            b = c % 32;
            dat[sel] = (b < 24) ? fv[s][23-b] : 1'b0;
            lr[sel]  = ((c >= n/2 - 1 && c <= n - 2) || (last && c == n - 1)) ? 1'b1 : 1'b0;
            tick();
        end
        for (int k = 0; k < nch; k++) begin
            if ((k*32 + 23 < n - 1) || (n == nch*32 && k*32 + 23 == n - 1)) m_sample(k, fv[k]);
        end
        if (n < nch*32) exp_err++;
    endtask

    task automatic check_step(input string tag);
        lr[sel] = 1'b1;
        dat[sel] = 1'b0;
        repeat (12) tick();
        chk({tag, ":count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({tag, ":word"}, 64'(got_q[i]), 64'(exp_q[i]));
        chk({tag, ":sync_err"}, 64'(got_err), 64'(exp_err));
        chk({tag, ":ovf"}, 64'(ovf[sel]), 64'(m_ovf[sel]));
        chk({tag, ":activate"}, 64'(act_w[sel]), 64'(m_act));
        got_q.delete();
        exp_q.delete();
        got_err = 0;
        exp_err = 0;
    endtask

    initial begin
        rst = 1'b1;
        en = 2'b00; lr = 2'b00; dat = 2'b00; se = 1'b0;
        cfg_min = 24'd0; cfg_size = 24'd0; cfg_ready = 2'b00;
        #1;
        chk("rst:activate", 64'(act_w[0]), 64'd0);
        chk("rst:strobe", 64'(stb_w[0]), 64'd0);
        chk("rst:data", 64'(dat_w[0]), 64'd0);
        chk("rst:sync_err", 64'(sync_err[0]), 64'd0);
        chk("rst:ovf", 64'(ovf[0]), 64'd0);
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Tag format, fixed frame.
        cfg_ready = 2'b01; cfg_size = 24'd4; cfg_min = 24'd100; se = 1'b0;
        set_en(1'b1);
        preamble();
        fv[0] = 24'h800001; fv[1] = 24'h123456;
        send_frame(64, 2, 1'b1);
        check_step("i2s_tag");

        // Sign-extended, same frame.
        set_en(1'b0);
        se = 1'b1;
        set_en(1'b1);
        preamble();
        send_frame(64, 2, 1'b1);
        check_step("i2s_sext");

        // Size-bounded burst, then FIFO1 takes over.
        set_en(1'b0);
        se = 1'b0; cfg_size = 24'd4; cfg_min = 24'd100; cfg_ready = 2'b01;
        set_en(1'b1);
        hook_n = 4; hook_val = 2'b10;
        preamble();
        for (int f = 0; f < 3; f++) begin
            rand_vals();
            send_frame(64, 2, f == 2);
        end
        check_step("size_rel");

        // Early release at min_read_size.
        set_en(1'b0);
        cfg_min = 24'd2; cfg_size = 24'd1000; cfg_ready = 2'b11; se = 1'($urandom_range(0, 1));
        set_en(1'b1);
        preamble();
        for (int f = 0; f < 2; f++) begin
            rand_vals();
            send_frame(64, 2, f == 1);
        end
        check_step("min_rel");

        // No FIFO ready: drops, plus one short frame.
        set_en(1'b0);
        cfg_ready = 2'b00; cfg_size = 24'd4; se = 1'b0;
        set_en(1'b1);
        preamble();
        rand_vals(); send_frame(64, 2, 1'b0);
        rand_vals(); send_frame(40, 2, 1'b0);
        rand_vals(); send_frame(64, 2, 1'b1);
        check_step("ovf");

        // Randomized configurations and frame lengths.
        for (int it = 0; it < 5; it++) begin
            set_en(1'b0);
            cfg_ready = 2'($urandom_range(0, 3));
            cfg_size  = 24'($urandom_range(0, 6));
            cfg_min   = 24'($urandom_range(0, 4));
            se        = 1'($urandom_range(0, 1));
            set_en(1'b1);
            preamble();
            for (int f = 0; f < 3; f++) begin
                rand_vals();
                if (f == 1 && $urandom_range(0, 1) == 1) send_frame(int'($urandom_range(20, 63)), 2, 1'b0);
                else send_frame(64, 2, f == 2);
            end
            check_step("rand");
        end

        // Reset in the middle of a slot.
        set_en(1'b0);
        cfg_ready = 2'b01; cfg_size = 24'd1000; cfg_min = 24'd1000; se = 1'b0;
        set_en(1'b1);
        preamble();
        for (int c = 0; c < 10; c++) begin
            dat[0] = 1'($urandom_range(0, 1));
            tick();
        end
        rst = 1'b1;
        #1;
        chk("midrst:activate", 64'(act_w[0]), 64'd0);
        chk("midrst:strobe", 64'(stb_w[0]), 64'd0);
        chk("midrst:data", 64'(dat_w[0]), 64'd0);
        chk("midrst:sync_err", 64'(sync_err[0]), 64'd0);
        chk("midrst:ovf", 64'(ovf[0]), 64'd0);
        m_ovf[0] = 0; m_act = 2'b00; m_cnt = 0;
        tick(); tick();
        rst = 1'b0;
        got_q.delete(); got_err = 0;
        lr[0] = 1'b0;
        repeat (3) tick();
        m_settle();
        for (int c = 0; c < 70; c++) begin
            dat[0] = 1'($urandom_range(0, 1));
            tick();
        end
        check_step("nosync");
        preamble();
        rand_vals();
        send_frame(64, 2, 1'b1);
        check_step("resync");

        // Four-slot TDM with a short frame 40 bits in.
        set_en(1'b0);
        sel = 1;
        cfg_ready = 2'b01; cfg_size = 24'd1000; cfg_min = 24'd1000; se = 1'b0;
        set_en(1'b1);
        preamble();
        rand_vals(); send_frame(128, 4, 1'b0);
        rand_vals(); send_frame(40, 4, 1'b0);
        rand_vals(); send_frame(128, 4, 1'b1);
        check_step("tdm");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
